decode: RTL and testbench

- Decode stage directly downstream of the fetch unit.
- Latches the 32-bit RV32I instruction that fetch presents under its four-phase compute_req/compute_valid handshake, then decodes it into registered fields.
- Hands the decoded fields to the execute stage over a second four-phase exec_req/exec_valid handshake.
- Acknowledges fetch only after execute has completed, or immediately if the instruction is illegal.

---
 rtl/decode.sv | 230 +++++++++++++++++++++++
 tb/tb_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// RV32I decode stage: latches one instruction from fetch, registers its decoded
// fields, and sequences the execute handshake before acknowledging fetch.
module decode #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] inst,
    input  logic                  compute_req,
    output logic                  compute_valid,
    output logic                  exec_req,
    input  logic                  exec_valid,
    output logic [6:0]            dec_opcode,
    output logic [4:0]            dec_rd,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [2:0]            dec_funct3,
    output logic [DATA_WIDTH-1:0] dec_imm,
    output logic [3:0]            dec_alu_op,
    output logic                  dec_illegal
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALU_W   = 4;

    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 3'd1;
    localparam logic [STATE_W-1:0] S_EXEC_REQ = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC_ACK = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE     = 3'd4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL   = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT   = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND   = 4'd9;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'd10;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  compute_valid_d, exec_req_d;
    logic                  load_inst, load_dec;

    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] imm_c;
    logic [ALU_W-1:0]      alu_op_c;
    logic                  illegal_c;

    // funct3 -> ALU op; alt selects SUB/SRA
    function automatic logic [ALU_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];
    assign funct7 = inst_q[31:25];

    // Combinational decode of the latched word
    always_comb begin
        imm_c     = '0;
        alu_op_c  = ALU_ADD;
        illegal_c = 1'b0;
        case (opcode)
            OP_LUI: begin
                imm_c    = {inst_q[31:12], 12'b0};
                alu_op_c = ALU_PASSB;
            end
            OP_AUIPC: imm_c = {inst_q[31:12], 12'b0};
            OP_JAL:   imm_c = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                               inst_q[30:21], 1'b0};
            OP_JALR: begin
                imm_c     = {{20{inst_q[31]}}, inst_q[31:20]};
                illegal_c = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                imm_c     = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                             inst_q[11:8], 1'b0};
                alu_op_c  = ALU_SUB;
                illegal_c = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                imm_c     = {{20{inst_q[31]}}, inst_q[31:20]};
                illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                imm_c     = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
                illegal_c = (funct3 >= 3'b011);
            end
            OP_IMM: begin
                imm_c    = {{20{inst_q[31]}}, inst_q[31:20]};
                alu_op_c = alu_sel(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b001)
                    illegal_c = (funct7 != F7_BASE);
                else if (funct3 == 3'b101)
                    illegal_c = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OP_OP: begin
                alu_op_c  = alu_sel(funct3, funct7 == F7_ALT);
                illegal_c = ((funct7 != F7_BASE) && (funct7 != F7_ALT)) ||
                            ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
            end
            default: illegal_c = 1'b1;
        endcase
        if (inst_q[1:0] != 2'b11)
            illegal_c = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state and next registered handshake outputs
    always_comb begin
        state_d         = state_q;
        compute_valid_d = compute_valid;
        exec_req_d      = exec_req;
        load_inst       = 1'b0;
        load_dec        = 1'b0;
        case (state_q)
            S_IDLE: begin
                compute_valid_d = 1'b0;
                exec_req_d      = 1'b0;
                if (compute_req) begin
                    load_inst = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                load_dec = 1'b1;
                if (illegal_c) begin
                    compute_valid_d = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    exec_req_d = 1'b1;
                    state_d    = S_EXEC_REQ;
                end
            end
            S_EXEC_REQ: begin
                exec_req_d = 1'b1;
                if (exec_valid) begin
                    exec_req_d = 1'b0;
                    state_d    = S_EXEC_ACK;
                end
            end
            S_EXEC_ACK: begin
                if (!exec_valid) begin
                    compute_valid_d = 1'b1;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                compute_valid_d = 1'b1;
                if (!compute_req) begin
                    compute_valid_d = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            default: begin
                compute_valid_d = 1'b0;
                exec_req_d      = 1'b0;
                state_d         = S_IDLE;
            end
        endcase
    end

    // Registered outputs and instruction latch; dec_* persist until the next decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q        <= '0;
            compute_valid <= 1'b0;
            exec_req      <= 1'b0;
            dec_opcode    <= '0;
            dec_rd        <= '0;
            dec_rs1       <= '0;
            dec_rs2       <= '0;
            dec_funct3    <= '0;
            dec_imm       <= '0;
            dec_alu_op    <= '0;
            dec_illegal   <= 1'b0;
        end else begin
            compute_valid <= compute_valid_d;
            exec_req      <= exec_req_d;
            if (load_inst)
                inst_q <= inst;
            if (load_dec) begin
                dec_opcode  <= opcode;
                dec_rd      <= inst_q[11:7];
                dec_rs1     <= inst_q[19:15];
                dec_rs2     <= inst_q[24:20];
                dec_funct3  <= funct3;
                dec_imm     <= imm_c;
                dec_alu_op  <= alu_op_c;
                dec_illegal <= illegal_c;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a driver pushes expected decodes, a monitor
// pops and compares whenever the stage presents a decoded instruction.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        compute_req, compute_valid, exec_req, exec_valid;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_illegal;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen_exec, prev_er, prev_cv;

    decode #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inst(inst),
        .compute_req(compute_req), .compute_valid(compute_valid),
        .exec_req(exec_req), .exec_valid(exec_valid),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_funct3(dec_funct3), .dec_imm(dec_imm), .dec_alu_op(dec_alu_op),
        .dec_illegal(dec_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [31:0] imm, input logic [3:0] alu, input logic ill);
        exp_t e;
        e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.imm = imm; e.alu = alu; e.ill = ill;
        return e;
    endfunction

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("mon_opcode", 32'(dec_opcode), 32'(e.opcode));
            chk("mon_rd", 32'(dec_rd), 32'(e.rd));
            chk("mon_rs1", 32'(dec_rs1), 32'(e.rs1));
            chk("mon_rs2", 32'(dec_rs2), 32'(e.rs2));
            chk("mon_funct3", 32'(dec_funct3), 32'(e.f3));
            chk("mon_imm", dec_imm, e.imm);
            chk("mon_alu_op", 32'(dec_alu_op), 32'(e.alu));
            chk("mon_illegal", 32'(dec_illegal), 32'(e.ill));
        end
    endtask

    // Monitor: exec_req rising presents a legal decode; compute_valid rising
    // without a preceding exec_req presents an illegal one.
    always @(negedge clk) begin
        if (!rst) begin
            seen_exec = 1'b0;
            prev_er   = 1'b0;
            prev_cv   = 1'b0;
        end else begin
            if (exec_req && !prev_er) begin
                pop_cmp();
                seen_exec = 1'b1;
            end
            if (compute_valid && !prev_cv) begin
                if (!seen_exec) pop_cmp();
                seen_exec = 1'b0;
            end
            prev_er = exec_req;
            prev_cv = compute_valid;
        end
    end

    task automatic chk_zero(input string name);
        chk({name, "_cv"}, 32'(compute_valid), 32'd0);
        chk({name, "_er"}, 32'(exec_req), 32'd0);
        chk({name, "_imm"}, dec_imm, 32'd0);
        chk({name, "_fields"}, 32'({dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3}), 32'd0);
        chk({name, "_alu_ill"}, 32'({dec_alu_op, dec_illegal}), 32'd0);
    endtask

    // One full fetch transaction; stall = cycles execute holds off its ack,
    // early = fetch drops compute_req while execute is still pending.
    task automatic txn(input logic [31:0] i, input exp_t e, input int stall, input bit early);
        @(negedge clk);
        inst = i;
        compute_req = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        inst = 32'hDEADBEEF;
        chk("decode_cycle_quiet", 32'({exec_req, compute_valid}), 32'd0);
        @(negedge clk);
        if (e.ill) begin
            chk("ill_cv_n2", 32'(compute_valid), 32'd1);
            chk("ill_er_n2", 32'(exec_req), 32'd0);
            @(negedge clk);
            chk("ill_er_hold", 32'(exec_req), 32'd0);
            chk("ill_cv_hold", 32'(compute_valid), 32'd1);
        end else begin
            chk("er_n2", 32'(exec_req), 32'd1);
            chk("cv_n2", 32'(compute_valid), 32'd0);
            for (int k = 0; k < stall; k++) begin
                if (early && k == 0) compute_req = 1'b0;
                @(negedge clk);
                chk("stall_er", 32'(exec_req), 32'd1);
                chk("stall_cv", 32'(compute_valid), 32'd0);
                chk("stall_imm", dec_imm, e.imm);
                chk("stall_rd", 32'(dec_rd), 32'(e.rd));
            end
            exec_valid = 1'b1;
            @(negedge clk);
            chk("ack_er_drop", 32'(exec_req), 32'd0);
            chk("ack_cv_low", 32'(compute_valid), 32'd0);
            exec_valid = 1'b0;
            @(negedge clk);
            chk("done_cv", 32'(compute_valid), 32'd1);
        end
        compute_req = 1'b0;
        @(negedge clk);
        chk("cv_fall", 32'(compute_valid), 32'd0);
        chk("idle_imm_kept", dec_imm, e.imm);
        chk("idle_alu_kept", 32'(dec_alu_op), 32'(e.alu));
    endtask

    initial begin
        rst         = 1'b0;
        inst        = '0;
        compute_req = 1'b0;
        exec_valid  = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // ADDI x1,x2,-5 with one-cycle execute
        txn(32'hFFB10093, mk(7'h13, 5'd1, 5'd2, 5'd27, 3'd0, 32'hFFFFFFFB, 4'd0, 1'b0), 0, 1'b0);
        // SUB x3,x1,x2
        txn(32'h402081B3, mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'h0, 4'd1, 1'b0), 1, 1'b0);
        // BEQ x1,x2,-8
        txn(32'hFE208CE3, mk(7'h63, 5'd25, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8, 4'd1, 1'b0), 0, 1'b0);
        // LUI x5,0x12345
        txn(32'h123452B7, mk(7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 32'h12345000, 4'd10, 1'b0), 0, 1'b0);
        // All-zero word is illegal
        txn(32'h00000000, mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 4'd0, 1'b1), 0, 1'b0);
        // SRAI x4,x5,3
        txn(32'h4032D213, mk(7'h13, 5'd4, 5'd5, 5'd3, 3'd5, 32'h00000403, 4'd7, 1'b0), 0, 1'b0);
        // LOAD with funct3=011 is illegal
        txn(32'h00013083, mk(7'h03, 5'd1, 5'd2, 5'd0, 3'd3, 32'h0, 4'd0, 1'b1), 0, 1'b0);
        // SW x2,12(x1), fetch drops its request early
        txn(32'h0020A623, mk(7'h23, 5'd12, 5'd1, 5'd2, 3'd2, 32'd12, 4'd0, 1'b0), 2, 1'b1);

        // Back-to-back with a 5-cycle execute stall
        txn(32'hFFB10093, mk(7'h13, 5'd1, 5'd2, 5'd27, 3'd0, 32'hFFFFFFFB, 4'd0, 1'b0), 5, 1'b0);
        txn(32'h402081B3, mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'h0, 4'd1, 1'b0), 5, 1'b0);

        // Stray exec_valid while idle is ignored
        exec_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stray_ack", 32'({exec_req, compute_valid}), 32'd0);
        end
        exec_valid = 1'b0;

        // Reset in the middle of EXEC_REQ aborts the transaction
        inst = 32'hFFB10093;
        compute_req = 1'b1;
        sb.push_back(mk(7'h13, 5'd1, 5'd2, 5'd27, 3'd0, 32'hFFFFFFFB, 4'd0, 1'b0));
        repeat (3) @(negedge clk);
        chk("pre_abort_er", 32'(exec_req), 32'd1);
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        compute_req = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'({exec_req, compute_valid}), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
